// File: rtl/quant_cfu_sequencer_pkg.sv
// quant_cfu_pkg: shared widths, CFU command codes and sequencer state type.
package quant_cfu_pkg;
    localparam int DATA_W = 32;
    localparam int BYTE_W = 8;
    localparam int LANES  = DATA_W / BYTE_W;
    localparam int CMD_W  = 7;
    localparam int CNT_W  = $clog2(LANES + 1);

    localparam logic [CMD_W-1:0] CMD_RESET       = 7'd0;
    localparam logic [CMD_W-1:0] CMD_SET_BIAS    = 7'd1;
    localparam logic [CMD_W-1:0] CMD_SET_MULT    = 7'd2;
    localparam logic [CMD_W-1:0] CMD_SET_SHIFT   = 7'd3;
    localparam logic [CMD_W-1:0] CMD_SET_ACT_MIN = 7'd4;
    localparam logic [CMD_W-1:0] CMD_SET_ACT_MAX = 7'd5;
    localparam logic [CMD_W-1:0] CMD_SET_OFFSET  = 7'd6;
    localparam logic [CMD_W-1:0] CMD_QUANT       = 7'd7;

    typedef enum logic [1:0] {IDLE, CFG, RUN} state_t;

    // Mask with the low n lanes set; n may equal LANES.
    function automatic logic [LANES-1:0] keep_mask(input logic [CNT_W-1:0] n);
        logic [LANES:0] m;
        m = ((LANES + 1)'(1) << n) - (LANES + 1)'(1);
        return m[LANES-1:0];
    endfunction
endpackage

// File: rtl/quant_cfu_sequencer_if.sv
// quant_cfu_sequencer_if: quant CFU command bus (cmd/inp0/inp1 out, ret back).
interface quant_cfu_sequencer_if;
    import quant_cfu_pkg::*;
    logic [CMD_W-1:0]  cfu_cmd;
    logic [DATA_W-1:0] cfu_inp0;
    logic [DATA_W-1:0] cfu_inp1;
    logic [DATA_W-1:0] cfu_ret;
    modport master (output cfu_cmd, cfu_inp0, cfu_inp1, input cfu_ret);
    modport slave  (input cfu_cmd, cfu_inp0, cfu_inp1, output cfu_ret);
endinterface

// File: rtl/quant_cfu_sequencer_packer.sv
// quant_byte_packer: gathers int8 results into 32-bit words with keep/last,
// holding a completed word in flush_pending while the output register is busy.
module quant_byte_packer
    import quant_cfu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cap,
    input  logic              cap_last,
    input  logic [BYTE_W-1:0] cap_byte,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [LANES-1:0]  out_keep,
    output logic              out_last
);
    logic [DATA_W-1:0] word_q, word_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_q, last_d, flush_pending, done, move;

    always_comb begin
        word_d = word_q;
        for (int i = 0; i < LANES; i++)
            word_d[i*BYTE_W +: BYTE_W] = (cap && cnt_q == CNT_W'(i)) ? cap_byte : word_q[i*BYTE_W +: BYTE_W];
        cnt_d  = cnt_q + CNT_W'(cap);
        last_d = last_q || (cap && cap_last);
        done   = flush_pending || (cap && (cnt_q == CNT_W'(LANES - 1) || cap_last));
        move   = done && (!out_valid || out_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_keep      <= '0;
            out_last      <= 1'b0;
            word_q        <= '0;
            cnt_q         <= '0;
            last_q        <= 1'b0;
            flush_pending <= 1'b0;
        end else if (move) begin
            out_valid     <= 1'b1;
            out_data      <= word_d;
            out_keep      <= keep_mask(cnt_d);
            out_last      <= last_d;
            word_q        <= '0;
            cnt_q         <= '0;
            last_q        <= 1'b0;
            flush_pending <= 1'b0;
        end else begin
            out_valid     <= out_valid && !out_ready;
            word_q        <= word_d;
            cnt_q         <= cnt_d;
            last_q        <= last_d;
            flush_pending <= done;
        end
    end
endmodule

// File: rtl/quant_cfu_sequencer.sv
// quant_cfu_sequencer: loads quant parameters into the CFU, then streams
// accumulators through CMD_QUANT and packs the int8 results four per word.
module quant_cfu_sequencer
    import quant_cfu_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [DATA_W-1:0]      cfg_bias,
    input  logic [DATA_W-1:0]      cfg_mult,
    input  logic [DATA_W-1:0]      cfg_shift,
    input  logic [DATA_W-1:0]      cfg_act_min,
    input  logic [DATA_W-1:0]      cfg_act_max,
    input  logic [DATA_W-1:0]      cfg_offset,
    input  logic                   acc_valid,
    output logic                   acc_ready,
    input  logic [DATA_W-1:0]      acc_data,
    input  logic                   acc_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [LANES-1:0]       out_keep,
    output logic                   out_last,
    quant_cfu_sequencer_if.master  cfu
);
    state_t            state;
    logic [2:0]        cnt;
    logic [DATA_W-1:0] prm [6];
    logic              last_pending, acc_hs;
    logic [1:0]        inf_v, inf_l;
    logic              unused_ret;

    assign cfg_ready     = state == IDLE;
    assign acc_ready     = state == RUN && !out_valid && !last_pending;
    assign acc_hs        = acc_valid && acc_ready;
    assign cfu.cfu_inp0  = '0;
    assign unused_ret    = ^cfu.cfu_ret[DATA_W-1:BYTE_W];

    // prm acts as a shift queue so CFG always issues prm[0] alongside cmd cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            last_pending <= 1'b0;
            inf_v        <= '0;
            inf_l        <= '0;
            cfu.cfu_cmd  <= CMD_RESET;
            cfu.cfu_inp1 <= '0;
            for (int i = 0; i < 6; i++) prm[i] <= '0;
        end else begin
            inf_v       <= {inf_v[0], acc_hs};
            inf_l       <= {inf_l[0], acc_hs && acc_last};
            cfu.cfu_cmd <= CMD_RESET;
            if (state == IDLE && cfg_valid) begin
                prm[0] <= cfg_bias;
                prm[1] <= cfg_mult;
                prm[2] <= cfg_shift;
                prm[3] <= cfg_act_min;
                prm[4] <= cfg_act_max;
                prm[5] <= cfg_offset;
                cnt    <= 3'd1;
                state  <= CFG;
            end
            if (state == CFG) begin
                cfu.cfu_cmd  <= CMD_W'(cnt);
                cfu.cfu_inp1 <= prm[0];
                for (int i = 0; i < 5; i++) prm[i] <= prm[i+1];
                cnt <= cnt + 3'd1;
                if (cnt == 3'd6) state <= RUN;
            end
            if (acc_hs) begin
                cfu.cfu_cmd  <= CMD_QUANT;
                cfu.cfu_inp1 <= acc_data;
                last_pending <= acc_last;
            end
            if (out_valid && out_ready && out_last) begin
                last_pending <= 1'b0;
                state        <= IDLE;
            end
        end
    end

    quant_byte_packer u_pack (
        .clk       (clk),
        .rst_n     (rst_n),
        .cap       (inf_v[1]),
        .cap_last  (inf_l[1]),
        .cap_byte  (cfu.cfu_ret[BYTE_W-1:0]),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last)
    );
endmodule

// File: tb/tb_quant_cfu_sequencer.sv
// tb_quant_cfu_sequencer: directed checks of config issue, streaming, packing,
// backpressure, flush collision and mid-stream reset against a simple CFU model.
module tb_quant_cfu_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid, cfg_ready;
    logic [31:0] cfg_bias, cfg_mult, cfg_shift, cfg_act_min, cfg_act_max, cfg_offset;
    logic        acc_valid, acc_ready, acc_last;
    logic [31:0] acc_data;
    logic        out_valid, out_ready, out_last;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] wd_q [$];
    logic [3:0]  wk_q [$];
    logic        wl_q [$];
    logic [31:0] cexp [6] = '{32'h5, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFF80, 32'h7F, 32'h3};

    quant_cfu_sequencer_if cfu ();

    always #5 clk = ~clk;

    // CFU stand-in: quantize returns the low byte of inp1, anything else clears ret.
    always @(posedge clk)
        cfu.cfu_ret <= (cfu.cfu_cmd == 7'd7) ? {24'h0, cfu.cfu_inp1[7:0]} : 32'h0;

    always @(posedge clk)
        if (rst_n && out_valid && out_ready) begin
            wd_q.push_back(out_data);
            wk_q.push_back(out_keep);
            wl_q.push_back(out_last);
        end

    quant_cfu_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_bias(cfg_bias), .cfg_mult(cfg_mult), .cfg_shift(cfg_shift),
        .cfg_act_min(cfg_act_min), .cfg_act_max(cfg_act_max), .cfg_offset(cfg_offset),
        .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_data(acc_data), .acc_last(acc_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_keep(out_keep), .out_last(out_last),
        .cfu(cfu)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic l);
        int n = 0;
        acc_valid = 1'b1;
        acc_data  = d;
        acc_last  = l;
        while (!acc_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) chk("push_timeout", 32'(acc_ready), 32'd1);
        step();
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!cfg_ready && n < 100) begin
            step();
            n++;
        end
        chk({tag, "_idle"}, 32'(cfg_ready), 32'd1);
        chk({tag, "_acc_rdy_low"}, 32'(acc_ready), 32'd0);
    endtask

    task automatic do_cfg(input string tag);
        int n = 0;
        cfg_valid = 1'b1;
        while (!cfg_ready && n < 50) begin
            step();
            n++;
        end
        step();
        cfg_valid = 1'b0;
        repeat (6) step();
        chk({tag, "_run"}, 32'(acc_ready), 32'd1);
    endtask

    task automatic pop_word(input string tag, input logic [31:0] d, input logic [3:0] k, input logic l);
        chk({tag, "_present"}, 32'(wd_q.size() > 0), 32'd1);
        if (wd_q.size() > 0) begin
            chk({tag, "_data"}, wd_q.pop_front(), d);
            chk({tag, "_keep"}, 32'(wk_q.pop_front()), 32'(k));
            chk({tag, "_last"}, 32'(wl_q.pop_front()), 32'(l));
        end
    endtask

    initial begin
        rst_n = 1'b0; cfg_valid = 1'b0; acc_valid = 1'b0; acc_data = '0; acc_last = 1'b0; out_ready = 1'b0;
        cfg_bias = 32'd5; cfg_mult = 32'h40000000; cfg_shift = 32'hFFFFFFFF;
        cfg_act_min = 32'hFFFFFF80; cfg_act_max = 32'h7F; cfg_offset = 32'd3;
        #12;
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("rst_acc_ready", 32'(acc_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_keep", 32'(out_keep), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_cmd", 32'(cfu.cfu_cmd), 32'd0);
        chk("rst_inp0", cfu.cfu_inp0, 32'd0);
        chk("rst_inp1", cfu.cfu_inp1, 32'd0);
        #10 rst_n = 1'b1;
        step();
        // Accumulators offered in IDLE are ignored.
        acc_valid = 1'b1; acc_data = 32'h77;
        chk("idle_acc_ready", 32'(acc_ready), 32'd0);
        step();
        chk("idle_cmd", 32'(cfu.cfu_cmd), 32'd0);
        acc_valid = 1'b0;

        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        chk("cfg_ready_low", 32'(cfg_ready), 32'd0);
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("cfg_cmd%0d", k + 1), 32'(cfu.cfu_cmd), 32'(k + 1));
            chk($sformatf("cfg_inp1_%0d", k + 1), cfu.cfu_inp1, cexp[k]);
        end
        chk("cfg_run", 32'(acc_ready), 32'd1);

        out_ready = 1'b1;
        push(32'h11, 1'b0); push(32'h22, 1'b0); push(32'h33, 1'b0); push(32'h44, 1'b0);
        chk("lat_e4", 32'(out_valid), 32'd0);
        push(32'h55, 1'b0);
        chk("lat_e5", 32'(out_valid), 32'd0);
        push(32'h66, 1'b0);
        chk("lat_word1_valid", 32'(out_valid), 32'd1);
        chk("lat_word1_data", out_data, 32'h44332211);
        push(32'h77, 1'b0); push(32'h88, 1'b1);
        acc_valid = 1'b0; acc_last = 1'b0;
        wait_idle("s1");
        pop_word("s1w1", 32'h44332211, 4'hF, 1'b0);
        pop_word("s1w2", 32'h88776655, 4'hF, 1'b1);
        chk("s1_count", 32'(wd_q.size()), 32'd0);

        do_cfg("p");
        for (int k = 1; k <= 6; k++) push(32'(k), k == 6);
        acc_valid = 1'b0; acc_last = 1'b0;
        wait_idle("p");
        pop_word("pw1", 32'h04030201, 4'hF, 1'b0);
        pop_word("pw2", 32'h00000605, 4'h3, 1'b1);
        chk("p_count", 32'(wd_q.size()), 32'd0);

        do_cfg("bp");
        out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) push(32'hA0 + 32'(k), 1'b0);
        acc_valid = 1'b0;
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_data", out_data, 32'hA4A3A2A1);
        for (int k = 0; k < 10; k++) begin
            step();
            chk("bp_hold_acc_ready", 32'(acc_ready), 32'd0);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_data", out_data, 32'hA4A3A2A1);
        end
        out_ready = 1'b1;
        push(32'hA7, 1'b0); push(32'hA8, 1'b1);
        acc_valid = 1'b0; acc_last = 1'b0;
        wait_idle("bp");
        pop_word("bpw1", 32'hA4A3A2A1, 4'hF, 1'b0);
        pop_word("bpw2", 32'hA8A7A6A5, 4'hF, 1'b1);
        chk("bp_count", 32'(wd_q.size()), 32'd0);

        do_cfg("fc");
        out_ready = 1'b0;
        push(32'h10, 1'b0); push(32'h20, 1'b0); push(32'h30, 1'b0); push(32'h40, 1'b0); push(32'h50, 1'b1);
        acc_valid = 1'b0; acc_last = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("fc_hold_valid", 32'(out_valid), 32'd1);
            chk("fc_hold_data", out_data, 32'h40302010);
            chk("fc_hold_last", 32'(out_last), 32'd0);
        end
        out_ready = 1'b1;
        step();
        chk("fc_w2_valid", 32'(out_valid), 32'd1);
        chk("fc_w2_data", out_data, 32'h00000050);
        chk("fc_w2_keep", 32'(out_keep), 32'h1);
        chk("fc_w2_last", 32'(out_last), 32'd1);
        wait_idle("fc");
        pop_word("fcw1", 32'h40302010, 4'hF, 1'b0);
        pop_word("fcw2", 32'h00000050, 4'h1, 1'b1);
        chk("fc_count", 32'(wd_q.size()), 32'd0);

        do_cfg("r");
        push(32'h99, 1'b0);
        acc_valid = 1'b0;
        chk("r_inflight_cmd", 32'(cfu.cfu_cmd), 32'd7);
        rst_n = 1'b0;
        #1;
        chk("r_cmd", 32'(cfu.cfu_cmd), 32'd0);
        chk("r_inp1", cfu.cfu_inp1, 32'd0);
        chk("r_out_valid", 32'(out_valid), 32'd0);
        chk("r_out_data", out_data, 32'd0);
        chk("r_out_keep", 32'(out_keep), 32'd0);
        chk("r_acc_ready", 32'(acc_ready), 32'd0);
        chk("r_cfg_ready", 32'(cfg_ready), 32'd1);
        #3 rst_n = 1'b1;
        step();
        acc_valid = 1'b1; acc_data = 32'h5A;
        for (int k = 0; k < 4; k++) begin
            chk("r_ign_acc_ready", 32'(acc_ready), 32'd0);
            step();
            chk("r_ign_cmd", 32'(cfu.cfu_cmd), 32'd0);
            chk("r_ign_valid", 32'(out_valid), 32'd0);
        end
        acc_valid = 1'b0;
        do_cfg("r2");
        push(32'h5A, 1'b1);
        acc_valid = 1'b0; acc_last = 1'b0;
        wait_idle("r2");
        pop_word("rw1", 32'h0000005A, 4'h1, 1'b1);
        chk("r_count", 32'(wd_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
